mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle control sequencer for the 5-bit-opcode processor core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the shared single-port memory, the PC/IR write enables, the register-file write controls and the ALU B-input select. It sits between the IR/PC datapath and the unified memory port, and replaces per-cycle combinational control with a handshake-aware state machine.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum cycles to wait for mem_ready before abort; only used with MC_CTRL_TIMEOUT_EN.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- run  in  1  level; high allows new instruction fetches.
- opcode  in  5  IR[31:27]; sampled in DECODE only.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write (sw data phase).
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  PC <= PC + 1.
- rf_we  out  1  register-file write.
- rf_wd_sel  out  1  0 = ALU result, 1 = memory read data.
- alu_inb_sel  out  1  0 = register rt, 1 = sign-extended immediate.
- instr_done  out  1  one-cycle pulse on instruction retire.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- busy  out  1  state != IDLE.
- bus_err  out  1  one-cycle pulse on memory timeout (0 when the macro is off).

## Operation
- Opcodes: ALU 00000, ADDI 00101, SW 00111, LW 01000. All others are illegal.
- op_q (5 b) latches opcode in DECODE and holds it through WB. All per-instruction outputs decode from op_q, never from the live opcode.
- States and transitions:
  - IDLE: run=1 -> FETCH.
  - FETCH: mem_req=1, mem_addr_sel=0. On mem_ready: ir_we=1, pc_we=1, -> DECODE. Otherwise stay in FETCH.
  - DECODE: capture op_q. Legal -> EXEC. Illegal -> illegal_op=1 and treat as retired (instr_done=0), then go to the next-state rule N.
  - EXEC: alu_inb_sel = (ADDI|SW|LW). ALU/ADDI -> WB. SW/LW -> MEM.
  - MEM: mem_req=1, mem_addr_sel=1, mem_we=SW, alu_inb_sel=1. On mem_ready: SW -> instr_done=1, then N. LW -> WB.
  - WB: rf_we=1, rf_wd_sel=LW, alu_inb_sel held. instr_done=1, then N.
- Next-state rule N: run=1 -> FETCH, run=0 -> IDLE.
- run deasserted mid-instruction: the current instruction completes, then the FSM goes to IDLE. No instruction is ever abandoned because of run.
- ir_we, pc_we and the MEM-state instr_done are Mealy outputs (state & mem_ready). All other outputs are Moore.
- mem_req is held high continuously until mem_ready. mem_addr_sel and mem_we are stable for the whole request.

## Timing
- Reset (synchronous, reset_n=0 at an edge): state=IDLE, op_q=0, wait counter=0. Every output is 0 in the following cycle. Reset wins over every other event, including a mid-request reset; the memory sees mem_req drop in the next cycle.
- Zero-wait memory (mem_ready in the first request cycle): ALU/ADDI = 4 cycles (F,D,E,W), SW = 4 (F,D,E,M), LW = 5 (F,D,E,M,W), illegal = 2 (F,D).
- Each wait cycle in FETCH or MEM adds 1 cycle.
- mem_ready outside FETCH/MEM is ignored.
- Back-to-back instructions: the cycle after WB, MEM(SW) or DECODE(illegal) is FETCH when run=1, with no bubble.

## Configuration
- MC_CTRL_TIMEOUT_EN defined:
  - A counter (width $clog2(MEM_TIMEOUT+1)) runs while in FETCH or MEM with mem_ready=0, and clears on state entry.
  - Reaching MEM_TIMEOUT: bus_err=1 for one cycle, mem_req drops, -> IDLE. No PC/IR/RF write occurs.
  - mem_ready in the same cycle as the terminal count wins, i.e. the request completes normally.
- Undefined: no counter. bus_err is tied to 0 and the FSM waits indefinitely.

## Structure
- Package mc_ctrl_pkg: opcode localparams (OP_ALU, OP_ADDI, OP_SW, OP_LW) and the state enum typedef (IDLE, FETCH, DECODE, EXEC, MEM, WB).
- One sub-module, mc_op_classify: combinational op_q -> {is_alu, is_addi, is_sw, is_lw, is_illegal}.

## Test plan
- ADDI, run=1, mem_ready always 1 -> states F,D,E,W. pc_we/ir_we in cycle 1, rf_we=1 with rf_wd_sel=0 and alu_inb_sel=1 in cycle 4, instr_done in cycle 4.
- LW with mem_ready delayed 3 cycles in MEM -> mem_req/mem_addr_sel=1 held for 4 cycles, then WB with rf_wd_sel=1. Total 8 cycles.
- SW then ALU back-to-back -> mem_we=1 only in MEM. FETCH of the ALU instruction starts the cycle after MEM. The ALU instruction shows rf_we=1 with alu_inb_sel=0.
- Opcode 11111 -> illegal_op pulse in DECODE, no rf_we/mem_we, next state FETCH. run dropped during an LW's MEM -> the LW completes, then IDLE, busy=0.
- reset_n=0 during a FETCH wait -> all outputs 0 next cycle, state IDLE. Restart with run=1 fetches normally.
- MC_CTRL_TIMEOUT_EN with MEM_TIMEOUT=16 and mem_ready stuck at 0 -> bus_err pulse after 16 wait cycles, then IDLE, with no pc_we. With the macro off -> still in FETCH after 100 cycles.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - opcode constants and state encoding for the multi-cycle control sequencer
package mc_ctrl_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } mc_state_e;

endpackage

// File: rtl/mc_op_classify.sv
// rtl/mc_op_classify.sv - combinational opcode classifier for the control sequencer
module mc_op_classify
  import mc_ctrl_pkg::*;
(
  input  logic [4:0] op,
  output logic       is_alu,
  output logic       is_addi,
  output logic       is_sw,
  output logic       is_lw,
  output logic       is_illegal
);

  always_comb begin
    is_alu     = (op == OP_ALU);
    is_addi    = (op == OP_ADDI);
    is_sw      = (op == OP_SW);
    is_lw      = (op == OP_LW);
    is_illegal = !(is_alu || is_addi || is_sw || is_lw);
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for the shared memory port
// Optional memory-wait abort is compiled in with MC_CTRL_TIMEOUT_EN.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  input  logic [4:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic       rf_wd_sel,
  output logic       alu_inb_sel,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       busy,
  output logic       bus_err
);

  mc_state_e  state;
  mc_state_e  state_next;
  logic [4:0] op_q;
  logic [4:0] dec_op;
  logic       is_alu;
  logic       is_addi;
  logic       is_sw;
  logic       is_lw;
  logic       is_illegal;
  logic       timeout_hit;
  logic       uses_imm;
  mc_state_e  retire_next;

  // DECODE must judge the opcode being captured; later states only see op_q.
  assign dec_op = (state == DECODE) ? opcode : op_q;

  mc_op_classify u_classify (
    .op         (dec_op),
    .is_alu     (is_alu),
    .is_addi    (is_addi),
    .is_sw      (is_sw),
    .is_lw      (is_lw),
    .is_illegal (is_illegal)
  );

  assign uses_imm    = is_addi || is_sw || is_lw;
  assign retire_next = run ? FETCH : IDLE;
  assign busy        = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      op_q  <= 5'd0;
    end else begin
      state <= state_next;
      if (state == DECODE) begin
        op_q <= opcode;
      end
    end
  end

`ifdef MC_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts unanswered request cycles; any state change restarts it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if ((state == FETCH || state == MEM) && !mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (wait_cnt == CNT_W'(MEM_TIMEOUT));
`else
  // Without the counter the sequencer waits on memory forever.
  assign timeout_hit = 1'b0 && (MEM_TIMEOUT != 0);
`endif

  always_comb begin
    state_next   = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    rf_we        = 1'b0;
    rf_wd_sel    = 1'b0;
    alu_inb_sel  = 1'b0;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    bus_err      = 1'b0;

    case (state)
      IDLE: begin
        if (run) begin
          state_next = FETCH;
        end
      end

      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = DECODE;
        end else if (timeout_hit) begin
          bus_err    = 1'b1;
          state_next = IDLE;
        end
      end

      DECODE: begin
        if (is_illegal) begin
          illegal_op = 1'b1;
          state_next = retire_next;
        end else begin
          state_next = EXEC;
        end
      end

      EXEC: begin
        alu_inb_sel = uses_imm;
        state_next  = (is_alu || is_addi) ? WB : MEM;
      end

      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_sw;
        alu_inb_sel  = 1'b1;
        if (mem_ready) begin
          if (is_sw) begin
            instr_done = 1'b1;
            state_next = retire_next;
          end else begin
            state_next = WB;
          end
        end else if (timeout_hit) begin
          bus_err    = 1'b1;
          state_next = IDLE;
        end
      end

      WB: begin
        rf_we       = 1'b1;
        rf_wd_sel   = is_lw;
        alu_inb_sel = uses_imm;
        instr_done  = 1'b1;
        state_next  = retire_next;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm (honours MC_CTRL_TIMEOUT_EN)
module tb_mc_control_fsm;

  localparam int MEM_TIMEOUT = 16;

  localparam logic [11:0] V_REQ   = 12'h800;
  localparam logic [11:0] V_WE    = 12'h400;
  localparam logic [11:0] V_ASEL  = 12'h200;
  localparam logic [11:0] V_IRWE  = 12'h100;
  localparam logic [11:0] V_PCWE  = 12'h080;
  localparam logic [11:0] V_RFWE  = 12'h040;
  localparam logic [11:0] V_WDSEL = 12'h020;
  localparam logic [11:0] V_INB   = 12'h010;
  localparam logic [11:0] V_DONE  = 12'h008;
  localparam logic [11:0] V_ILL   = 12'h004;
  localparam logic [11:0] V_BUSY  = 12'h002;
  localparam logic [11:0] V_BERR  = 12'h001;
  localparam logic [11:0] V_NONE  = 12'h000;

  typedef struct packed {
    logic       rst_n;
    logic       run;
    logic [4:0] op;
    logic       rdy;
  } stim_t;

  stim_t       stim_q[$];
  logic [11:0] exp_q[$];
  string       tag_q[$];

  int checks   = 0;
  int failures = 0;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       run;
  logic [4:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we;
  logic       rf_wd_sel, alu_inb_sel, instr_done, illegal_op, busy, bus_err;
  logic [11:0] obs;

  mc_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .run          (run),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .rf_we        (rf_we),
    .rf_wd_sel    (rf_wd_sel),
    .alu_inb_sel  (alu_inb_sel),
    .instr_done   (instr_done),
    .illegal_op   (illegal_op),
    .busy         (busy),
    .bus_err      (bus_err)
  );

  always #5 clock = ~clock;

  assign obs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we,
                rf_wd_sel, alu_inb_sel, instr_done, illegal_op, busy, bus_err};

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b (req,we,asel,irwe,pcwe,rfwe,wdsel,inb,done,ill,busy,berr)",
               tag, got, want);
    end
  endtask

  function automatic logic [4:0] rnd_op();
    return 5'($urandom);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  task automatic push(input logic rst_n, input logic r, input logic [4:0] op,
                      input logic rdy, input logic [11:0] want, input string tag);
    stim_t s;
    s.rst_n = rst_n;
    s.run   = r;
    s.op    = op;
    s.rdy   = rdy;
    stim_q.push_back(s);
    exp_q.push_back(want);
    tag_q.push_back(tag);
  endtask

  task automatic push_idle(input logic r, input string tag);
    push(1'b1, r, rnd_op(), rnd_bit(), V_NONE, tag);
  endtask

  // Expected per-cycle trace of one instruction, built from the cycle table of the sequencer.
  task automatic push_instr(input logic [4:0] op, input int fw, input int mw,
                            input logic run_lvl, input string name);
    logic        is_sw, is_lw, imm, legal;
    logic [11:0] mem_base;
    is_sw = (op == 5'b00111);
    is_lw = (op == 5'b01000);
    imm   = (op == 5'b00101) || is_sw || is_lw;
    legal = imm || (op == 5'b00000);
    for (int i = 0; i < fw; i++)
      push(1'b1, 1'b1, rnd_op(), 1'b0, V_REQ | V_BUSY, $sformatf("%s_fwait%0d", name, i));
    push(1'b1, 1'b1, rnd_op(), 1'b1, V_REQ | V_IRWE | V_PCWE | V_BUSY, {name, "_fetch"});
    push(1'b1, run_lvl, op, rnd_bit(), V_BUSY | (legal ? V_NONE : V_ILL), {name, "_decode"});
    if (!legal) return;
    push(1'b1, run_lvl, rnd_op(), rnd_bit(), V_BUSY | (imm ? V_INB : V_NONE), {name, "_exec"});
    if (is_sw || is_lw) begin
      mem_base = V_REQ | V_ASEL | V_INB | V_BUSY | (is_sw ? V_WE : V_NONE);
      for (int i = 0; i < mw; i++)
        push(1'b1, run_lvl, rnd_op(), 1'b0, mem_base, $sformatf("%s_mwait%0d", name, i));
      push(1'b1, run_lvl, rnd_op(), 1'b1, mem_base | (is_sw ? V_DONE : V_NONE), {name, "_mem"});
    end
    if (!is_sw)
      push(1'b1, run_lvl, rnd_op(), rnd_bit(),
           V_RFWE | (is_lw ? V_WDSEL : V_NONE) | (imm ? V_INB : V_NONE) | V_DONE | V_BUSY,
           {name, "_wb"});
  endtask

  initial begin
    stim_t       s;
    logic [11:0] want;
    string       tag;

    reset_n   = 1'b0;
    run       = 1'b0;
    opcode    = 5'd0;
    mem_ready = 1'b0;

    push(1'b1, 1'b0, 5'd0, 1'b1, V_NONE, "reset_state");
    push_idle(1'b1, "idle_start");
    push_instr(5'b00101, 0, 0, 1'b1, "addi");
    push_instr(5'b01000, 0, 3, 1'b1, "lw_slow");
    push_instr(5'b00111, 1, 0, 1'b1, "sw");
    push_instr(5'b00000, 0, 0, 1'b1, "alu");
    push_instr(5'b11111, 0, 0, 1'b1, "illegal");
    push_instr(5'b01000, 0, 1, 1'b0, "lw_stop");
    push_idle(1'b0, "idle_after_lw0");
    push_idle(1'b0, "idle_after_lw1");
    push_idle(1'b1, "idle_restart");
    push_instr(5'b00000, MEM_TIMEOUT, 0, 1'b1, "alu_tc_ready");

    push(1'b1, 1'b1, rnd_op(), 1'b0, V_REQ | V_BUSY, "rst_fwait0");
    push(1'b1, 1'b1, rnd_op(), 1'b0, V_REQ | V_BUSY, "rst_fwait1");
    push(1'b0, 1'b1, rnd_op(), 1'b0, V_REQ | V_BUSY, "rst_edge");
    push(1'b1, 1'b0, rnd_op(), 1'b1, V_NONE, "post_reset");
    push_idle(1'b1, "idle_after_reset");
    push_instr(5'b00101, 0, 0, 1'b0, "addi_after_reset");
    push_idle(1'b0, "idle_end_addi");

    push_idle(1'b1, "idle_stuck");
`ifdef MC_CTRL_TIMEOUT_EN
    for (int i = 0; i < MEM_TIMEOUT; i++)
      push(1'b1, 1'b1, rnd_op(), 1'b0, V_REQ | V_BUSY, $sformatf("to_wait%0d", i));
    push(1'b1, 1'b1, rnd_op(), 1'b0, V_REQ | V_BUSY | V_BERR, "to_bus_err");
    push_idle(1'b0, "to_idle");
`else
    for (int i = 0; i < 100; i++)
      push(1'b1, 1'b1, rnd_op(), 1'b0, V_REQ | V_BUSY, $sformatf("stuck_wait%0d", i));
    push(1'b0, 1'b1, rnd_op(), 1'b0, V_REQ | V_BUSY, "stuck_reset");
    push_idle(1'b0, "stuck_idle");
`endif

    repeat (2) @(posedge clock);
    #1;
    while (stim_q.size() > 0) begin
      s    = stim_q.pop_front();
      want = exp_q.pop_front();
      tag  = tag_q.pop_front();
      reset_n   = s.rst_n;
      run       = s.run;
      opcode    = s.op;
      mem_ready = s.rdy;
      @(negedge clock);
      check_eq(tag, obs, want);
      @(posedge clock);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
